// File: rtl/act_mem_reader.sv
// Activation memory read sequencer: sweeps (entry, y, x) in order and streams
// each registered word with its coordinates over a valid/ready interface.
module act_mem_reader #(
    parameter int ENTRY_NUM = 1,
    parameter int DIM       = 1,
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          read_index_entry,
    output logic [15:0]          read_index_y,
    output logic [15:0]          read_index_x,
    input  logic [DATA_SIZE-1:0] mem_data,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [15:0]          out_entry,
    output logic [15:0]          out_y,
    output logic [15:0]          out_x,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [15:0] E_LAST = 16'(ENTRY_NUM - 1);
    localparam logic [15:0] D_LAST = 16'(DIM - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t      state;
    logic [15:0] cnt_e, cnt_y, cnt_x;
    logic        load;
    logic        at_last;

    // The output register is free when empty or being consumed this cycle.
    assign load    = !out_valid || out_ready;
    assign at_last = (cnt_e == E_LAST) && (cnt_y == D_LAST) && (cnt_x == D_LAST);

    assign read_index_entry = cnt_e;
    assign read_index_y     = cnt_y;
    assign read_index_x     = cnt_x;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt_e     <= '0;
            cnt_y     <= '0;
            cnt_x     <= '0;
            out_data  <= '0;
            out_entry <= '0;
            out_y     <= '0;
            out_x     <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_e <= '0;
                        cnt_y <= '0;
                        cnt_x <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (load) begin
                        out_data  <= mem_data;
                        out_entry <= cnt_e;
                        out_y     <= cnt_y;
                        out_x     <= cnt_x;
                        out_valid <= 1'b1;
                        out_last  <= at_last;
                        // Counters park on the final location until the next start.
                        if (at_last) begin
                            state <= DRAIN;
                        end else if (cnt_x == D_LAST) begin
                            cnt_x <= '0;
                            if (cnt_y == D_LAST) begin
                                cnt_y <= '0;
                                cnt_e <= cnt_e + 16'd1;
                            end else begin
                                cnt_y <= cnt_y + 16'd1;
                            end
                        end else begin
                            cnt_x <= cnt_x + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_mem_reader.sv
// Directed bench for act_mem_reader: 2x2x2, 1x1x1 and 1x3x3 sweeps with
// stalls, start-while-busy and mid-sweep reset.
module tb_act_mem_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ENTRY_NUM=2, DIM=2 instance
    logic        st22 = 1'b0, rdy22 = 1'b0;
    logic        busy22, done22, last22, vld22;
    logic [15:0] ri22_e, ri22_y, ri22_x, o22_e, o22_y, o22_x;
    logic [63:0] mem22, o22_data;

    // ENTRY_NUM=1, DIM=1 instance
    logic        st11 = 1'b0, rdy11 = 1'b0;
    logic        busy11, done11, last11, vld11;
    logic [15:0] ri11_e, ri11_y, ri11_x, o11_e, o11_y, o11_x;
    logic [63:0] mem11, o11_data;

    // ENTRY_NUM=1, DIM=3 instance
    logic        st13 = 1'b0, rdy13 = 1'b0;
    logic        busy13, done13, last13, vld13;
    logic [15:0] ri13_e, ri13_y, ri13_x, o13_e, o13_y, o13_x;
    logic [63:0] mem13, o13_data;

    always_comb mem22 = $realtobits(real'(int'(ri22_e) * 4 + int'(ri22_y) * 2 + int'(ri22_x) + 1));
    always_comb mem11 = $realtobits(3.5);
    always_comb mem13 = $realtobits(real'(int'(ri13_e) * 9 + int'(ri13_y) * 3 + int'(ri13_x) + 1));

    act_mem_reader #(.ENTRY_NUM(2), .DIM(2), .DATA_SIZE(64)) u22 (
        .clk(clk), .rst(rst), .start(st22), .busy(busy22), .done(done22),
        .read_index_entry(ri22_e), .read_index_y(ri22_y), .read_index_x(ri22_x),
        .mem_data(mem22), .out_data(o22_data), .out_entry(o22_e), .out_y(o22_y),
        .out_x(o22_x), .out_last(last22), .out_valid(vld22), .out_ready(rdy22));

    act_mem_reader #(.ENTRY_NUM(1), .DIM(1), .DATA_SIZE(64)) u11 (
        .clk(clk), .rst(rst), .start(st11), .busy(busy11), .done(done11),
        .read_index_entry(ri11_e), .read_index_y(ri11_y), .read_index_x(ri11_x),
        .mem_data(mem11), .out_data(o11_data), .out_entry(o11_e), .out_y(o11_y),
        .out_x(o11_x), .out_last(last11), .out_valid(vld11), .out_ready(rdy11));

    act_mem_reader #(.ENTRY_NUM(1), .DIM(3), .DATA_SIZE(64)) u13 (
        .clk(clk), .rst(rst), .start(st13), .busy(busy13), .done(done13),
        .read_index_entry(ri13_e), .read_index_y(ri13_y), .read_index_x(ri13_x),
        .mem_data(mem13), .out_data(o13_data), .out_entry(o13_e), .out_y(o13_y),
        .out_x(o13_x), .out_last(last13), .out_valid(vld13), .out_ready(rdy13));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {data, tags, last} for the k-th (1-based) beat of the 2x2x2 sweep.
    function automatic logic [127:0] exp22(input int k);
        int l = k - 1;
        return {15'b0, $realtobits(real'(k)), 16'(l / 4), 16'((l / 2) % 2), 16'(l % 2), k == 8};
    endfunction

    function automatic logic [47:0] ridx22(input int r);
        return {16'(r / 4), 16'((r / 2) % 2), 16'(r % 2)};
    endfunction

    typedef struct {
        bit st;
        bit rdy;
        bit vld;
        int idx;   // expected beat number, 0 = data not checked
        int ridx;  // expected linear read index, -1 = not checked
        bit done;
        bit busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, input bit rdy, input bit vld, input int idx,
                       input int ridx, input bit done, input bit busy);
        vec_t v;
        v.st = st; v.rdy = rdy; v.vld = vld; v.idx = idx;
        v.ridx = ridx; v.done = done; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic sweep22(input int pulse_at);
        int beat = 0;
        int dones = 0;
        @(negedge clk);
        st22 = 1'b1; rdy22 = 1'b1;
        @(negedge clk);
        st22 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (vld22 && rdy22) begin
                beat++;
                chk("sweep_beat", {15'b0, o22_data, o22_e, o22_y, o22_x, last22}, exp22(beat));
            end
            if (done22) dones++;
            st22 = (pulse_at != 0 && beat == pulse_at && vld22);
            @(negedge clk);
        end
        st22 = 1'b0;
        chk("sweep_beats", 128'(beat), 128'd8);
        chk("sweep_dones", 128'(dones), 128'd1);
        chk("sweep_busy_end", 128'(busy22), 128'd0);
    endtask

    initial begin
        // Full-rate sweep: rows checked at each falling edge, then inputs driven.
        add(1, 1, 0, 0, -1, 0, 0);
        add(0, 1, 0, 0,  0, 0, 1);
        add(0, 1, 1, 1,  1, 0, 1);
        add(0, 1, 1, 2,  2, 0, 1);
        add(0, 1, 1, 3,  3, 0, 1);
        add(0, 1, 1, 4,  4, 0, 1);
        add(0, 1, 1, 5,  5, 0, 1);
        add(0, 1, 1, 6,  6, 0, 1);
        add(0, 1, 1, 7,  7, 0, 1);
        add(0, 1, 1, 8,  7, 0, 1);
        add(0, 1, 0, 0,  7, 1, 0);
        add(1, 1, 0, 0,  7, 0, 0);
        // Stalled sweep, ready pattern 1,0,0 repeating.
        add(0, 1, 0, 0,  0, 0, 1);
        add(0, 0, 1, 1,  1, 0, 1);
        add(0, 0, 1, 1,  1, 0, 1);
        add(0, 1, 1, 1,  1, 0, 1);
        add(0, 0, 1, 2,  2, 0, 1);
        add(0, 0, 1, 2,  2, 0, 1);
        add(0, 1, 1, 2,  2, 0, 1);
        add(0, 0, 1, 3,  3, 0, 1);
        add(0, 0, 1, 3,  3, 0, 1);
        add(0, 1, 1, 3,  3, 0, 1);
        add(0, 0, 1, 4,  4, 0, 1);
        add(0, 0, 1, 4,  4, 0, 1);
        add(0, 1, 1, 4,  4, 0, 1);
        add(0, 0, 1, 5,  5, 0, 1);
        add(0, 0, 1, 5,  5, 0, 1);
        add(0, 1, 1, 5,  5, 0, 1);
        add(0, 0, 1, 6,  6, 0, 1);
        add(0, 0, 1, 6,  6, 0, 1);
        add(0, 1, 1, 6,  6, 0, 1);
        add(0, 0, 1, 7,  7, 0, 1);
        add(0, 0, 1, 7,  7, 0, 1);
        add(0, 1, 1, 7,  7, 0, 1);
        add(0, 0, 1, 8,  7, 0, 1);
        add(0, 0, 1, 8,  7, 0, 1);
        add(0, 1, 1, 8,  7, 0, 1);
        add(0, 1, 0, 0,  7, 1, 0);
        add(0, 1, 0, 0,  7, 0, 0);

        // Reset state, all instances.
        repeat (2) @(negedge clk);
        chk("rst_22", {vld22, last22, done22, busy22, ri22_e, ri22_y, ri22_x, o22_e, o22_y, o22_x}, '0);
        chk("rst_22_data", 128'(o22_data), '0);
        chk("rst_11", {vld11, last11, done11, busy11, ri11_e, ri11_y, ri11_x, o11_e, o11_y, o11_x}, '0);
        chk("rst_13", {vld13, last13, done13, busy13, ri13_e, ri13_y, ri13_x, o13_e, o13_y, o13_x}, '0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            chk($sformatf("row%0d_valid", i), 128'(vld22), 128'(tbl[i].vld));
            chk($sformatf("row%0d_done", i), 128'(done22), 128'(tbl[i].done));
            chk($sformatf("row%0d_busy", i), 128'(busy22), 128'(tbl[i].busy));
            if (tbl[i].idx > 0)
                chk($sformatf("row%0d_beat", i), {15'b0, o22_data, o22_e, o22_y, o22_x, last22}, exp22(tbl[i].idx));
            if (tbl[i].ridx >= 0)
                chk($sformatf("row%0d_ridx", i), 128'({ri22_e, ri22_y, ri22_x}), 128'(ridx22(tbl[i].ridx)));
            st22  = tbl[i].st;
            rdy22 = tbl[i].rdy;
            @(negedge clk);
        end

        // start pulsed mid-sweep is ignored; then a fresh sweep after done.
        sweep22(3);
        sweep22(0);

        // Asynchronous reset while beat 5 is presented.
        st22 = 1'b1; rdy22 = 1'b1;
        @(negedge clk);
        st22 = 1'b0;
        for (int c = 0; c < 12 && !(vld22 && o22_data == $realtobits(5.0)); c++) @(negedge clk);
        chk("prerst_beat5", {15'b0, o22_data, o22_e, o22_y, o22_x, last22}, exp22(5));
        rst = 1'b1;
        #1;
        chk("midrst_state", {vld22, busy22, done22, ri22_e, ri22_y, ri22_x}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_idle", {vld22, busy22, done22}, '0);
        sweep22(0);

        // Single element with a 4-cycle stall.
        st11 = 1'b1; rdy11 = 1'b0;
        @(negedge clk);
        st11 = 1'b0;
        chk("one_p0", {vld11, busy11, ri11_e, ri11_y, ri11_x}, {2'b01, 48'd0});
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("one_hold%0d", c), {o11_data, o11_e, o11_y, o11_x, last11, vld11, done11, busy11},
                {$realtobits(3.5), 48'd0, 4'b1101});
            if (c == 3) rdy11 = 1'b1;
            @(negedge clk);
        end
        chk("one_done", {vld11, done11, busy11, last11}, 4'b0100);
        rdy11 = 1'b0;
        @(negedge clk);
        chk("one_done_clr", {vld11, done11, busy11}, 3'b000);

        // DIM=3 wrap order of the read index and output tags.
        st13 = 1'b1; rdy13 = 1'b1;
        @(negedge clk);
        st13 = 1'b0;
        begin
            int k = 0;
            for (int c = 0; c < 16 && k < 9; c++) begin
                @(negedge clk);
                if (vld13) begin
                    chk($sformatf("d3_beat%0d", k), {15'b0, o13_data, o13_e, o13_y, o13_x, last13},
                        {15'b0, $realtobits(real'(k + 1)), 16'd0, 16'(k / 3), 16'(k % 3), k == 8});
                    if (k < 8)
                        chk($sformatf("d3_ridx%0d", k), 128'({ri13_e, ri13_y, ri13_x}),
                            128'({16'd0, 16'((k + 1) / 3), 16'((k + 1) % 3)}));
                    k++;
                end
            end
            chk("d3_count", 128'(k), 128'd9);
        end
        @(negedge clk);
        chk("d3_done", {done13, busy13, vld13}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
